// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - page encodings, scheduler states and 50 MHz default timing for the display page scheduler
package display_pkg;

    localparam logic [1:0] PAGE_LOW  = 2'd0;
    localparam logic [1:0] PAGE_MID  = 2'd1;
    localparam logic [1:0] PAGE_HIGH = 2'd2;
    localparam logic [1:0] PAGE_MIX  = 2'd3;

    typedef enum logic [1:0] {
        S_SHOW  = 2'd0,
        S_BLANK = 2'd1,
        S_LOAD  = 2'd2
    } sched_state_t;

    localparam int DEF_DWELL_CYCLES    = 50000000;
    localparam int DEF_BLANK_CYCLES    = 5000000;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_CNT_W           = 32;

    function automatic logic [1:0] next_page(input logic [1:0] page);
        return (page == PAGE_MIX) ? PAGE_LOW : page + 2'd1;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronizes the step button and emits a one-cycle pulse on its rising edge; DISPLAY_SCHED_DEBOUNCE_EN adds a level filter
module button_conditioner
`ifdef DISPLAY_SCHED_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 32
)
`endif
(
    input  logic iCLK,
    input  logic iRST_n,
    input  logic iBtn,
    output logic oStep
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

`ifdef DISPLAY_SCHED_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_db_cnt;
    logic             r_filt;

    // The filtered level flips only after the raw level has differed from it for a full run.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_db_cnt <= '0;
            r_filt   <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt <= '0;
            r_filt   <= r_sync2;
        end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= iBtn;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

    assign oStep = w_level & ~r_prev;

endmodule

// File: rtl/display_page_scheduler.sv
// rtl/display_page_scheduler.sv - steps the display page select through four views of a frozen 64-bit snapshot; DISPLAY_SCHED_DEBOUNCE_EN debounces iNext
import display_pkg::*;

module display_page_scheduler #(
    parameter int DWELL_CYCLES    = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES    = DEF_BLANK_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [63:0] iData,
    input  logic        iAuto,
    input  logic        iNext,
    input  logic        iFreeze,
    output logic [1:0]  oSelect,
    output logic [63:0] oData,
    output logic        oBlank,
    output logic        oPageStrobe
);

    localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = HAS_BLANK ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    sched_state_t     r_state;
    sched_state_t     w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_auto_s1;
    logic             r_auto_s2;
    logic             w_step;
    logic [1:0]       r_select;
    logic [63:0]      r_data;
    logic             r_blank;
    logic             r_strobe;

    button_conditioner
`ifdef DISPLAY_SCHED_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    )
`endif
    u_next_cond (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iBtn   (iNext),
        .oStep  (w_step)
    );

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
            r_state   <= S_SHOW;
            r_cnt     <= '0;
        end else begin
            r_auto_s1 <= iAuto;
            r_auto_s2 <= r_auto_s1;
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
        end
    end

    // One counter serves both the dwell and the blank interval; it is cleared on every state exit.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_SHOW: begin
                if (iFreeze) begin
                    w_cnt_next = r_cnt;
                end else if ((r_auto_s2 && (r_cnt == DWELL_LAST)) || w_step) begin
                    w_next_state = HAS_BLANK ? S_BLANK : S_LOAD;
                    w_cnt_next   = '0;
                end else if (r_auto_s2) begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_next = '0;
                end
            end
            S_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_next_state = S_LOAD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            S_LOAD: begin
                w_next_state = S_SHOW;
                w_cnt_next   = '0;
            end
            default: begin
                w_next_state = S_SHOW;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered so select, snapshot and strobe change together on one edge.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_select <= PAGE_LOW;
            r_data   <= '0;
            r_blank  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_blank  <= (r_state == S_BLANK);
            r_strobe <= (r_state == S_LOAD);
            if (r_state == S_LOAD) begin
                r_select <= next_page(r_select);
                r_data   <= iData;
            end
        end
    end

    assign oSelect     = r_select;
    assign oData       = r_data;
    assign oBlank      = r_blank;
    assign oPageStrobe = r_strobe;

endmodule

// File: tb/tb_display_page_scheduler.sv
// tb/tb_display_page_scheduler.sv - checks two scheduler builds (with and without blanking) against a phase-count model
module tb_display_page_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data;
    logic        auto_in, next_in, frz;

    logic [1:0]  sel_a, sel_b;
    logic [63:0] data_a, data_b;
    logic        blank_a, blank_b, strobe_a, strobe_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    display_page_scheduler #(.DWELL_CYCLES(8), .BLANK_CYCLES(2), .DEBOUNCE_CYCLES(16), .CNT_W(8)) u_dut_a (
        .iCLK(clk), .iRST_n(rst_n), .iData(data), .iAuto(auto_in), .iNext(next_in), .iFreeze(frz),
        .oSelect(sel_a), .oData(data_a), .oBlank(blank_a), .oPageStrobe(strobe_a)
    );

    display_page_scheduler #(.DWELL_CYCLES(8), .BLANK_CYCLES(0), .DEBOUNCE_CYCLES(16), .CNT_W(8)) u_dut_b (
        .iCLK(clk), .iRST_n(rst_n), .iData(data), .iAuto(auto_in), .iNext(next_in), .iFreeze(frz),
        .oSelect(sel_b), .oData(data_b), .oBlank(blank_b), .oPageStrobe(strobe_b)
    );

    typedef struct {
        int          age;
        int          blank_left;
        bit          load;
        logic [1:0]  sel;
        logic [63:0] dat;
        bit          blank;
        bit          strobe;
    } mdl_t;

    mdl_t ma, mb;
    bit   n1, n2, n3, a1, a2;
    int   qa[$], qb[$];
    logic [1:0] qsa[$];

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.age = 0; m.blank_left = 0; m.load = 0; m.sel = 2'd0;
        m.dat = '0; m.blank = 0; m.strobe = 0;
        return m;
    endfunction

    // Visible outputs after an edge reflect the phase the page was in just before that edge.
    function automatic mdl_t mdl_edge(mdl_t m, int dwell, int blank_len, bit auto_on,
                                      bit step, bit freeze, logic [63:0] d);
        mdl_t r = m;
        r.strobe = m.load;
        r.blank  = (m.blank_left > 0);
        if (m.load) begin
            r.sel  = m.sel + 2'd1;
            r.dat  = d;
            r.load = 0;
            r.age  = 0;
        end else if (m.blank_left > 0) begin
            r.blank_left = m.blank_left - 1;
            if (r.blank_left == 0) r.load = 1;
        end else if (!freeze) begin
            if ((auto_on && m.age == dwell - 1) || step) begin
                r.age = 0;
                if (blank_len > 0) r.blank_left = blank_len;
                else r.load = 1;
            end else begin
                r.age = auto_on ? m.age + 1 : 0;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = mdl_reset(); mb = mdl_reset();
            n1 = 0; n2 = 0; n3 = 0; a1 = 0; a2 = 0;
            cyc = 0;
        end else begin
            bit step;
            cyc++;
            step = n2 & ~n3;
            ma = mdl_edge(ma, 8, 2, a2, step, frz, data);
            mb = mdl_edge(mb, 8, 0, a2, step, frz, data);
            n3 = n2; n2 = n1; n1 = next_in;
            a2 = a1; a1 = auto_in;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("a_select", 64'(sel_a), 64'(ma.sel));
            check("a_data", data_a, ma.dat);
            check("a_blank", 64'(blank_a), 64'(ma.blank));
            check("a_strobe", 64'(strobe_a), 64'(ma.strobe));
            check("b_select", 64'(sel_b), 64'(mb.sel));
            check("b_data", data_b, mb.dat);
            check("b_blank", 64'(blank_b), 64'(mb.blank));
            check("b_strobe", 64'(strobe_b), 64'(mb.strobe));
            if (strobe_a) begin qa.push_back(cyc); qsa.push_back(sel_a); end
            if (strobe_b) qb.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            data = {$urandom, $urandom};
        end
    endtask

    task automatic do_reset(input bit auto_v);
        @(negedge clk);
        #2 rst_n = 1'b0;
        auto_in = auto_v; next_in = 1'b0; frz = 1'b0;
        repeat (2) @(negedge clk);
        qa.delete(); qsa.delete(); qb.delete();
        rst_n = 1'b1;
    endtask

    task automatic pulse_next(input int len);
        next_in = 1'b1;
        tick(len);
        next_in = 1'b0;
    endtask

    initial begin
        int t0;
        logic [63:0] held;
        rst_n = 1'b0; data = 64'h0123456789ABCDEF;
        auto_in = 1'b1; next_in = 1'b0; frz = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_sel_a", 64'(sel_a), 64'd0);
        check("rst_data_a", data_a, 64'd0);
        check("rst_blank_a", 64'(blank_a), 64'd0);
        check("rst_strobe_a", 64'(strobe_a), 64'd0);
        check("rst_sel_b", 64'(sel_b), 64'd0);
        check("rst_data_b", data_b, 64'd0);

        // Auto mode: first strobe after sync delay plus dwell, then fixed period.
        rst_n = 1'b1;
        for (int i = 0; i < 200 && qa.size() < 4; i++) tick(1);
        tick(1);
        check("auto_four_strobes", 64'(qa.size() >= 4), 64'd1);
        if (qa.size() >= 4) begin
            check("auto_first_strobe_a", 64'(qa[0]), 64'd13);
            for (int i = 1; i < 4; i++) check("auto_period_a", 64'(qa[i] - qa[i-1]), 64'd11);
            for (int i = 0; i < 4; i++) check("auto_page_seq", 64'(qsa[i]), 64'((i + 1) % 4));
        end
        if (qb.size() >= 2) begin
            check("auto_first_strobe_b", 64'(qb[0]), 64'd11);
            check("auto_period_b", 64'(qb[1] - qb[0]), 64'd9);
        end else begin
            check("auto_strobes_b", 64'(qb.size()), 64'd2);
        end

        // Manual: a 4-cycle press gives exactly one advance.
        do_reset(1'b0);
        tick(5);
        t0 = cyc;
        pulse_next(4);
        for (int i = 0; i < 50 && qa.size() < 1; i++) tick(1);
        tick(1);
        check("manual_strobes_b", 64'(qb.size()), 64'd1);
        if (qb.size() >= 1) check("manual_latency_b", 64'(qb[0] - t0), 64'd4);
        if (qa.size() >= 1) check("manual_latency_a", 64'(qa[0] - t0), 64'd6);
        else check("manual_strobes_a", 64'(qa.size()), 64'd1);
        tick(1000);
        check("manual_hold_sel_b", 64'(sel_b), 64'd1);
        check("manual_hold_sel_a", 64'(sel_a), 64'd1);
        check("manual_hold_count_a", 64'(qa.size()), 64'd1);

        // Freeze on page 1 of the blank-free build at count 5; steps during freeze are dropped.
        do_reset(1'b1);
        tick(16);
        frz = 1'b1;
        held = data_b;
        tick(14);
        pulse_next(3);
        tick(10);
        pulse_next(5);
        tick(18);
        check("freeze_cycle", 64'(cyc), 64'd66);
        check("freeze_no_strobe_b", 64'(qb.size()), 64'd1);
        check("freeze_data_b", data_b, held);
        frz = 1'b0;
        for (int i = 0; i < 20 && qb.size() < 2; i++) tick(1);
        if (qb.size() >= 2) check("freeze_release_b", 64'(qb[1]), 64'd70);
        else check("freeze_release_count_b", 64'(qb.size()), 64'd2);

        // Step in auto mode cuts the dwell short.
        tick(3);
        t0 = qb.size();
        pulse_next(2);
        tick(4);
        check("auto_step_b", 64'(qb.size()), 64'(t0 + 1));

        // Async reset in the middle of a blank interval.
        do_reset(1'b1);
        for (int i = 0; i < 100 && !(blank_a && qa.size() >= 1); i++) tick(1);
        check("midblank_reached", 64'(blank_a), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midblank_sel_a", 64'(sel_a), 64'd0);
        check("midblank_data_a", data_a, 64'd0);
        check("midblank_blank_a", 64'(blank_a), 64'd0);
        check("midblank_strobe_a", 64'(strobe_a), 64'd0);
        check("midblank_sel_b", 64'(sel_b), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("post_reset_no_strobe", 64'(strobe_a | strobe_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
